// File: rtl/pipeline_perf_monitor.sv
// pipeline_perf_monitor
//   Performance and retirement-trace monitor for the write-back stage of
//   cpu_pipelined. It counts active cycles, retired instructions, retired
//   instructions per opcode class and generic event strobes. Counting runs over
//   a start / end-of-program window that ends with a fixed pipeline-drain
//   phase. It can also keep a show-ahead FIFO of retired (PC, instruction) pairs.
//
//   Optional feature macro: PERF_TRACE_FIFO_EN
//     defined   -> trace FIFO and sticky overflow flag are built
//     undefined -> trace outputs tied to 0, trace_ready ignored
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   start          pulse: clear counters/FIFO and enter RUN (from IDLE or DONE)
//   end_program    level: RUN -> DRAIN (or DONE when DRAIN_CYCLES = 0)
//   retire_valid   an instruction retires this cycle
//   retire_pc      PC of the retiring instruction
//   retire_instr   encoding of the retiring instruction
//   event_in       per-cycle event strobes
//   rd_sel         counter select (0 cyc, 1 ret, 2..7 classes, 8+k events)
//   rd_data        registered counter read, one cycle latency
//   state          0 IDLE, 1 RUN, 2 DRAIN, 3 DONE
//   done           high in DONE
//   trace_valid    FIFO head valid
//   trace_ready    pop the FIFO head
//   trace_pc       head PC
//   trace_instr    head instruction
//   trace_overflow sticky: a retirement was dropped on a full FIFO
module pipeline_perf_monitor #(
    parameter int CNT_W        = 32,
    parameter int XLEN         = 64,
    parameter int NUM_EVENTS   = 4,
    parameter int DRAIN_CYCLES = 5,
    parameter int TRACE_DEPTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  end_program,
    input  logic                  retire_valid,
    input  logic [XLEN-1:0]       retire_pc,
    input  logic [31:0]           retire_instr,
    input  logic [NUM_EVENTS-1:0] event_in,
    input  logic [3:0]            rd_sel,
    output logic [CNT_W-1:0]      rd_data,
    output logic [1:0]            state,
    output logic                  done,
    output logic                  trace_valid,
    input  logic                  trace_ready,
    output logic [XLEN-1:0]       trace_pc,
    output logic [31:0]           trace_instr,
    output logic                  trace_overflow
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // The drain counter holds "cycles left after this one", so DRAIN lasts
    // exactly DRAIN_CYCLES cycles.
    localparam logic [7:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? 8'(DRAIN_CYCLES - 1) : 8'd0;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_drain_cnt;
    logic [7:0]       w_drain_nxt;
    logic             w_clear;
    logic             w_active;

    logic [CNT_W-1:0] r_cyc;
    logic [CNT_W-1:0] r_ret;
    logic [CNT_W-1:0] r_cls [6];
    logic [CNT_W-1:0] r_evt [NUM_EVENTS];
    logic [2:0]       w_cls;
    logic [CNT_W-1:0] w_rd_mux;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Class index 0..5 = R-type, load, store, branch, op-imm, other.
    function automatic logic [2:0] classify(input logic [6:0] opcode);
        case (opcode)
            7'b0110011: return 3'd0;
            7'b0000011: return 3'd1;
            7'b0100011: return 3'd2;
            7'b1100011: return 3'd3;
            7'b0010011: return 3'd4;
            default:    return 3'd5;
        endcase
    endfunction

    // ---------------- control state machine ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_drain_cnt <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_cnt;
        w_clear     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_clear     = 1'b1;
                end
            end
            S_RUN: begin
                if (end_program) begin
                    if (DRAIN_CYCLES == 0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_DRAIN;
                        w_drain_nxt = DRAIN_LOAD;
                    end
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == 8'd0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_drain_nxt = r_drain_cnt - 8'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_active = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign state    = r_state;
    assign done     = (r_state == S_DONE);
    assign w_cls    = classify(retire_instr[6:0]);

    // ---------------- counters ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cyc <= '0;
            r_ret <= '0;
            for (int i = 0; i < 6; i++) r_cls[i] <= '0;
            for (int k = 0; k < NUM_EVENTS; k++) r_evt[k] <= '0;
        end else if (w_clear) begin
            r_cyc <= '0;
            r_ret <= '0;
            for (int i = 0; i < 6; i++) r_cls[i] <= '0;
            for (int k = 0; k < NUM_EVENTS; k++) r_evt[k] <= '0;
        end else if (w_active) begin
            r_cyc <= sat_inc(r_cyc);
            if (retire_valid) begin
                r_ret        <= sat_inc(r_ret);
                r_cls[w_cls] <= sat_inc(r_cls[w_cls]);
            end
            for (int k = 0; k < NUM_EVENTS; k++) begin
                if (event_in[k]) r_evt[k] <= sat_inc(r_evt[k]);
            end
        end
    end

    // ---------------- counter read port ----------------
    always_comb begin
        w_rd_mux = '0;
        if (rd_sel == 4'd0) begin
            w_rd_mux = r_cyc;
        end else if (rd_sel == 4'd1) begin
            w_rd_mux = r_ret;
        end else if (!rd_sel[3]) begin
            w_rd_mux = r_cls[rd_sel[2:0] - 3'd2];
        end else begin
            for (int k = 0; k < NUM_EVENTS; k++) begin
                if (rd_sel[2:0] == 3'(k)) w_rd_mux = r_evt[k];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= w_rd_mux;
        end
    end

    // ---------------- retirement trace FIFO ----------------
`ifdef PERF_TRACE_FIFO_EN
    localparam int              PTR_W    = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(TRACE_DEPTH);
    localparam logic [PTR_W:0]  ONE_CNT  = (PTR_W + 1)'(1);

    logic [XLEN-1:0]  r_fifo_pc    [TRACE_DEPTH];
    logic [31:0]      r_fifo_instr [TRACE_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;
    logic             r_overflow;
    logic             w_pop;
    logic             w_push_req;
    logic             w_push;

    assign w_pop      = (r_count != '0) && trace_ready;
    assign w_push_req = retire_valid && w_active;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push     = w_push_req && ((r_count != FULL_CNT) || w_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (w_clear) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_push && !w_pop) begin
                r_count <= r_count + ONE_CNT;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - ONE_CNT;
            end
            if (w_push_req && !w_push) r_overflow <= 1'b1;
        end
    end

    // Storage needs no reset: the head is masked by trace_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= retire_pc;
            r_fifo_instr[r_wr_ptr] <= retire_instr;
        end
    end

    assign trace_valid    = (r_count != '0);
    assign trace_pc       = trace_valid ? r_fifo_pc[r_rd_ptr]    : '0;
    assign trace_instr    = trace_valid ? r_fifo_instr[r_rd_ptr] : '0;
    assign trace_overflow = r_overflow;
`else
    logic w_unused_trace;

    assign w_unused_trace = ^{trace_ready, retire_pc, retire_instr[31:7]};
    assign trace_valid    = 1'b0;
    assign trace_pc       = '0;
    assign trace_instr    = '0;
    assign trace_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_perf_monitor.sv
module tb_pipeline_perf_monitor;

`ifdef PERF_TRACE_FIFO_EN
    localparam bit FIFO_EN = 1'b1;
`else
    localparam bit FIFO_EN = 1'b0;
`endif
    localparam int     DEPTH = 8;
    localparam int     DRAIN = 5;
    localparam longint CMAX  = 64'h0000_0000_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        end_program = 1'b0;
    logic        retire_valid = 1'b0;
    logic [63:0] retire_pc = '0;
    logic [31:0] retire_instr = '0;
    logic [3:0]  event_in = '0;
    logic [3:0]  rd_sel = '0;
    logic [31:0] rd_data;
    logic [1:0]  state;
    logic        done;
    logic        trace_valid;
    logic        trace_ready = 1'b0;
    logic [63:0] trace_pc;
    logic [31:0] trace_instr;
    logic        trace_overflow;

    // Second instance: narrow counters, no drain phase.
    logic        start_s = 1'b0;
    logic        end_s = 1'b0;
    logic [3:0]  rd_sel_s = '0;
    logic [3:0]  rd_data_s;
    logic [1:0]  state_s;
    logic        done_s;
    logic        unused_tv_s;
    logic [63:0] unused_pc_s;
    logic [31:0] unused_in_s;
    logic        unused_ov_s;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: state as integer, counters as plain saturating integers
    // indexed by read select, trace as a queue.
    int          m_state;
    int          m_left;
    longint      m_cnt [16];
    bit          m_ovf;
    logic [63:0] q_pc [$];
    logic [31:0] q_in [$];
    logic [31:0] exp_rd;

    pipeline_perf_monitor #(.CNT_W(32), .XLEN(64), .NUM_EVENTS(4),
                            .DRAIN_CYCLES(DRAIN), .TRACE_DEPTH(DEPTH)) u_dut (
        .clk(clk), .reset(reset), .start(start), .end_program(end_program),
        .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_instr(retire_instr),
        .event_in(event_in), .rd_sel(rd_sel), .rd_data(rd_data), .state(state), .done(done),
        .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_pc(trace_pc),
        .trace_instr(trace_instr), .trace_overflow(trace_overflow)
    );

    pipeline_perf_monitor #(.CNT_W(4), .XLEN(64), .NUM_EVENTS(2),
                            .DRAIN_CYCLES(0), .TRACE_DEPTH(2)) u_sat (
        .clk(clk), .reset(reset), .start(start_s), .end_program(end_s),
        .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_instr(retire_instr),
        .event_in(event_in[1:0]), .rd_sel(rd_sel_s), .rd_data(rd_data_s), .state(state_s),
        .done(done_s), .trace_valid(unused_tv_s), .trace_ready(trace_ready),
        .trace_pc(unused_pc_s), .trace_instr(unused_in_s), .trace_overflow(unused_ov_s)
    );

    always #5 clk = ~clk;

    function automatic int cls_sel(input logic [31:0] ins);
        case (ins[6:0])
            7'b0110011: return 2;
            7'b0000011: return 3;
            7'b0100011: return 4;
            7'b1100011: return 5;
            7'b0010011: return 6;
            default:    return 7;
        endcase
    endfunction

    task automatic bump(input int i);
        if (m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
    endtask

    task automatic model_reset();
        m_state = 0;
        m_left  = 0;
        for (int i = 0; i < 16; i++) m_cnt[i] = 0;
        m_ovf = 1'b0;
        q_pc.delete();
        q_in.delete();
        exp_rd = '0;
    endtask

    // Advance the model by one clock using the current inputs, then clock the DUT.
    task automatic step();
        bit act;
        bit accept;
        exp_rd = m_cnt[rd_sel][31:0];
        act    = (m_state == 1) || (m_state == 2);
        accept = ((m_state == 0) || (m_state == 3)) && start;
        if (act) begin
            bump(0);
            if (retire_valid) begin
                bump(1);
                bump(cls_sel(retire_instr));
            end
            for (int k = 0; k < 4; k++) if (event_in[k]) bump(8 + k);
        end
        if (FIFO_EN) begin
            if (accept) begin
                q_pc.delete();
                q_in.delete();
                m_ovf = 1'b0;
            end else begin
                if (trace_ready && q_pc.size() > 0) begin
                    void'(q_pc.pop_front());
                    void'(q_in.pop_front());
                end
                if (act && retire_valid) begin
                    if (q_pc.size() < DEPTH) begin
                        q_pc.push_back(retire_pc);
                        q_in.push_back(retire_instr);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
        end
        case (m_state)
            0, 3: if (start) begin
                m_state = 1;
                for (int i = 0; i < 16; i++) m_cnt[i] = 0;
            end
            1: if (end_program) begin
                if (DRAIN == 0) m_state = 3;
                else begin
                    m_state = 2;
                    m_left  = DRAIN;
                end
            end
            2: begin
                m_left = m_left - 1;
                if (m_left == 0) m_state = 3;
            end
            default: m_state = 0;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic finish_program();
        end_program = 1'b1;
        step();
        end_program = 1'b0;
        for (int i = 0; i < 20 && done !== 1'b1; i++) step();
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL drain_timeout done=%b required 1", done);
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if (state !== 2'd0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state state=%0d done=%b required 0/0", state, done);
        end
        n_vec++;
        if (rd_data !== 32'd0) begin
            n_err++;
            $display("FAIL reset_rd_data got %0h required 0", rd_data);
        end
        n_vec++;
        if (trace_valid !== 1'b0 || trace_pc !== 64'd0 || trace_instr !== 32'd0 || trace_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset_trace v=%b pc=%0h in=%0h ov=%b required all 0",
                     trace_valid, trace_pc, trace_instr, trace_overflow);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_program();
        logic [31:0] prog [6];
        bit          vld [6];
        int          sels [5];
        logic [31:0] reqs [5];
        prog = '{32'h0000_3083, 32'h0, 32'h0010_0093, 32'h0020_81B3, 32'h0, 32'h0020_81B3};
        vld  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        sels = '{0, 1, 3, 6, 2};
        reqs = '{32'd12, 32'd4, 32'd1, 32'd1, 32'd2};
        start = 1'b1;
        step();
        start = 1'b0;
        n_vec++;
        if (state !== 2'd1) begin
            n_err++;
            $display("FAIL prog_enter_run state=%0d required 1", state);
        end
        for (int i = 0; i < 6; i++) begin
            retire_valid = vld[i];
            retire_instr = prog[i];
            retire_pc    = 64'h100 + 64'(4 * i);
            step();
        end
        retire_valid = 1'b0;
        end_program  = 1'b1;
        step();
        end_program  = 1'b0;
        for (int i = 0; i < DRAIN - 1; i++) begin
            n_vec++;
            if (state !== 2'd2 || done !== 1'b0) begin
                n_err++;
                $display("FAIL prog_drain%0d state=%0d done=%b required 2/0", i, state, done);
            end
            step();
        end
        step();
        n_vec++;
        if (state !== 2'd3 || done !== 1'b1) begin
            n_err++;
            $display("FAIL prog_done state=%0d done=%b required 3/1", state, done);
        end
        for (int i = 0; i < 5; i++) begin
            rd_sel = 4'(sels[i]);
            step();
            n_vec++;
            if (rd_data !== reqs[i]) begin
                n_err++;
                $display("FAIL prog_read sel%0d got %0d required %0d", sels[i], rd_data, reqs[i]);
            end
        end
    endtask

    task automatic test_events();
        int          sels [6];
        logic [31:0] reqs [6];
        sels = '{8, 9, 10, 11, 15, 12};
        reqs = '{32'd7, 32'd0, 32'd7, 32'd0, 32'd0, 32'd0};
        start = 1'b1;
        step();
        start = 1'b0;
        event_in = 4'b0101;
        for (int i = 0; i < 7; i++) step();
        event_in = 4'b0000;
        finish_program();
        for (int i = 0; i < 6; i++) begin
            rd_sel = 4'(sels[i]);
            step();
            n_vec++;
            if (rd_data !== reqs[i]) begin
                n_err++;
                $display("FAIL event_read sel%0d got %0d required %0d", sels[i], rd_data, reqs[i]);
            end
        end
    endtask

    task automatic test_saturation();
        start_s = 1'b1;
        step();
        start_s = 1'b0;
        n_vec++;
        if (state_s !== 2'd1) begin
            n_err++;
            $display("FAIL sat_enter_run state=%0d required 1", state_s);
        end
        event_in = 4'b0001;
        for (int i = 0; i < 19; i++) step();
        event_in = 4'b0000;
        end_s = 1'b1;
        step();
        end_s = 1'b0;
        n_vec++;
        if (state_s !== 2'd3 || done_s !== 1'b1) begin
            n_err++;
            $display("FAIL sat_no_drain state=%0d done=%b required 3/1", state_s, done_s);
        end
        rd_sel_s = 4'd0;
        step();
        n_vec++;
        if (rd_data_s !== 4'd15) begin
            n_err++;
            $display("FAIL sat_cycles got %0d required 15", rd_data_s);
        end
        rd_sel_s = 4'd8;
        step();
        n_vec++;
        if (rd_data_s !== 4'd15) begin
            n_err++;
            $display("FAIL sat_event0 got %0d required 15", rd_data_s);
        end
    endtask

    task automatic test_restart_ignored();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            retire_valid = 1'b1;
            retire_instr = 32'h0000_0013;
            retire_pc    = 64'h400 + 64'(4 * i);
            step();
        end
        retire_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        n_vec++;
        if (state !== 2'd1) begin
            n_err++;
            $display("FAIL restart_state got %0d required 1", state);
        end
        step();
        step();
        rd_sel = 4'd0;
        step();
        n_vec++;
        if (rd_data !== 32'd6 || rd_data !== exp_rd) begin
            n_err++;
            $display("FAIL restart_cycles got %0d required 6", rd_data);
        end
    endtask

    task automatic test_reset_mid_drain();
        end_program = 1'b1;
        step();
        end_program = 1'b0;
        step();
        step();
        n_vec++;
        if (state !== 2'd2) begin
            n_err++;
            $display("FAIL middrain_state got %0d required 2", state);
        end
        reset = 1'b0;
        #1;
        n_vec++;
        if (state !== 2'd0 || done !== 1'b0 || rd_data !== 32'd0 || trace_valid !== 1'b0 || trace_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL middrain_reset state=%0d done=%b rd=%0h tv=%b ov=%b required all 0",
                     state, done, rd_data, trace_valid, trace_overflow);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        for (int s = 0; s < 16; s++) begin
            rd_sel = 4'(s);
            step();
            n_vec++;
            if (rd_data !== 32'd0) begin
                n_err++;
                $display("FAIL postreset_read sel%0d got %0h required 0", s, rd_data);
            end
        end
    endtask

`ifdef PERF_TRACE_FIFO_EN
    task automatic test_fifo_overflow();
        start = 1'b1;
        step();
        start = 1'b0;
        trace_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            retire_valid = 1'b1;
            retire_pc    = 64'h2000 + 64'(8 * i);
            retire_instr = $urandom();
            step();
        end
        retire_valid = 1'b0;
        n_vec++;
        if (trace_overflow !== 1'b1 || trace_valid !== 1'b1) begin
            n_err++;
            $display("FAIL fifo_overflow ov=%b tv=%b required 1/1", trace_overflow, trace_valid);
        end
        trace_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (trace_pc !== 64'h2000 + 64'(8 * i) || trace_instr !== q_in[0]) begin
                n_err++;
                $display("FAIL fifo_order%0d pc=%0h required %0h", i, trace_pc, 64'h2000 + 64'(8 * i));
            end
            step();
        end
        n_vec++;
        if (trace_valid !== 1'b0) begin
            n_err++;
            $display("FAIL fifo_empty tv=%b required 0", trace_valid);
        end
        trace_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        finish_program();
        start = 1'b1;
        step();
        start = 1'b0;
        trace_ready  = 1'b0;
        retire_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            retire_pc = 64'h3000 + 64'(8 * i);
            step();
        end
        retire_pc   = 64'h3040;
        trace_ready = 1'b1;
        step();
        retire_valid = 1'b0;
        n_vec++;
        if (trace_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL fullpp_overflow got %b required 0", trace_overflow);
        end
        for (int i = 1; i <= 8; i++) begin
            n_vec++;
            if (trace_valid !== 1'b1 || trace_pc !== 64'h3000 + 64'(8 * i)) begin
                n_err++;
                $display("FAIL fullpp_pop%0d tv=%b pc=%0h required 1/%0h", i, trace_valid, trace_pc,
                         64'h3000 + 64'(8 * i));
            end
            step();
        end
        n_vec++;
        if (trace_valid !== 1'b0) begin
            n_err++;
            $display("FAIL fullpp_empty tv=%b required 0", trace_valid);
        end
        trace_ready = 1'b0;
    endtask
`else
    task automatic test_fifo_tied_off();
        logic [31:0] r;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            r = $urandom();
            retire_valid = 1'b1;
            retire_pc    = {$urandom(), $urandom()};
            retire_instr = r;
            trace_ready  = r[0];
            step();
            n_vec++;
            if (trace_valid !== 1'b0 || trace_pc !== 64'd0 || trace_instr !== 32'd0 || trace_overflow !== 1'b0) begin
                n_err++;
                $display("FAIL tied_off%0d tv=%b pc=%0h in=%0h ov=%b required all 0",
                         i, trace_valid, trace_pc, trace_instr, trace_overflow);
            end
        end
        retire_valid = 1'b0;
        trace_ready  = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic [31:0] r;
        logic [31:0] r2;
        logic [6:0]  ops [8];
        logic [63:0] hp;
        logic [31:0] hi;
        ops = '{7'h33, 7'h03, 7'h23, 7'h63, 7'h13, 7'h37, 7'h6F, 7'h7F};
        for (int c = 0; c < 600; c++) begin
            r  = $urandom();
            r2 = $urandom();
            start        = ((m_state == 0) || (m_state == 3)) ? (r[1:0] == 2'd0) : (r[4:0] == 5'd0);
            end_program  = (r[9:5] == 5'd0);
            retire_valid = r[10];
            trace_ready  = ((c % 200) < 80) ? (r[13:11] == 3'd0) : r[11];
            rd_sel       = r[17:14];
            event_in     = r[21:18];
            retire_instr = (r[27:25] == 3'd0) ? 32'd0 : {r2[31:7], ops[r[24:22]]};
            retire_pc    = {$urandom(), $urandom()};
            step();
            hp = (q_pc.size() > 0) ? q_pc[0] : 64'd0;
            hi = (q_in.size() > 0) ? q_in[0] : 32'd0;
            n_vec++;
            if (rd_data !== exp_rd) begin
                n_err++;
                $display("FAIL rand_rd c%0d got %0h required %0h", c, rd_data, exp_rd);
            end
            n_vec++;
            if (state !== 2'(m_state) || done !== (m_state == 3)) begin
                n_err++;
                $display("FAIL rand_state c%0d got %0d/%b required %0d", c, state, done, m_state);
            end
            n_vec++;
            if (trace_valid !== (q_pc.size() > 0) || trace_pc !== hp || trace_instr !== hi) begin
                n_err++;
                $display("FAIL rand_trace c%0d tv=%b pc=%0h in=%0h required %0d/%0h/%0h",
                         c, trace_valid, trace_pc, trace_instr, q_pc.size(), hp, hi);
            end
            n_vec++;
            if (trace_overflow !== m_ovf) begin
                n_err++;
                $display("FAIL rand_overflow c%0d got %b required %b", c, trace_overflow, m_ovf);
            end
        end
        start = 1'b0;
        end_program = 1'b0;
        retire_valid = 1'b0;
        trace_ready = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_program();
        test_events();
        test_saturation();
        test_restart_ignored();
        test_reset_mid_drain();
`ifdef PERF_TRACE_FIFO_EN
        test_fifo_overflow();
        test_full_push_pop();
`else
        test_fifo_tied_off();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
